// File: rtl/st_bus_pkg.sv
// Shared types and defaults for the ST bus initiator.
package st_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ_BUS,
    WAIT_FREE,
    OWN,
    S_ADDR,
    S_STRB,
    S_WAIT,
    S_DATA,
    S_END,
    RELEASE
  } state_t;

  localparam int DTACK_TIMEOUT_DEF = 64;
  localparam int HOLD_IDLE_DEF     = 4;
  localparam int TMR_W             = 8;

endpackage

// File: rtl/bus_arbiter.sv
// BR/BG/BGACK bus arbitration: acquires the ST bus and hands it back on request.
// state     | meaning
// IDLE      | bus not wanted, BR/BGACK released
// REQ_BUS   | BR low, waiting for BG
// WAIT_FREE | granted, waiting for current master to finish (AS, DTACK, BGACK high)
// OWN       | BGACK low, bus ours
// RELEASE   | BGACK back high, pads still enabled for one clock
module bus_arbiter
  import st_bus_pkg::*;
(
  input  logic CLK8,
  input  logic RST,
  input  logic REQ,
  input  logic BG,
  input  logic BGACK_IN,
  input  logic AS_IN,
  input  logic DTACK,
  input  logic RELEASE_REQ,
  output logic BR,
  output logic BGACK_OUT,
  output logic BUS_OE,
  output logic OWNED
);

  state_t state, state_nxt;

  always_ff @(posedge CLK8) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (REQ) state_nxt = REQ_BUS;
      REQ_BUS:   if (!BG) state_nxt = WAIT_FREE;
      WAIT_FREE: begin
        // grant withdrawn takes priority over a bus that just went free
        if (BG)                              state_nxt = REQ_BUS;
        else if (AS_IN && DTACK && BGACK_IN) state_nxt = OWN;
      end
      OWN:       if (RELEASE_REQ) state_nxt = RELEASE;
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BR        = !((state == REQ_BUS) || (state == WAIT_FREE));
    BGACK_OUT = (state != OWN);
    BUS_OE    = (state == OWN) || (state == RELEASE);
    OWNED     = (state == OWN);
  end

endmodule

// File: rtl/st_bus_master.sv
// 68000-style ST bus initiator running single read/write cycles for a DMA engine.
// state   | meaning
// IDLE    | no bus cycle in progress (bus owned or not, see arbiter)
// S_ADDR  | address and RW driven, write data enabled
// S_STRB  | AS low, read strobes low
// S_WAIT  | all selected strobes low, waiting for DTACK/BERR/timeout
// S_DATA  | DTACK seen, read data latched on exit
// S_END   | strobes released, RW and data drive held
module st_bus_master
  import st_bus_pkg::*;
#(
  parameter int DTACK_TIMEOUT = DTACK_TIMEOUT_DEF,
  parameter int HOLD_IDLE     = HOLD_IDLE_DEF
) (
  input  logic        CLK8,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_A,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [15:0] REQ_WD,
  input  logic        REQ_LOCK,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RD,
  output logic        BR,
  input  logic        BG,
  input  logic        BGACK_IN,
  output logic        BGACK_OUT,
  input  logic        AS_IN,
  input  logic        DTACK,
  input  logic        BERR,
  output logic        AS_OUT,
  output logic        UDS_OUT,
  output logic        LDS_OUT,
  output logic        RW_OUT,
  output logic [22:0] A_OUT,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        BUS_OE,
  output logic        D_OE
);

  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(DTACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_IDLE - 1);

  logic bg_q, bgack_q, as_q, dtack_q, berr_q;
  logic owned, release_req, req_go, req_bad, fin_ok, fin_err, idle_tick;
  logic in_cyc, as_low, strb_low;
  logic [TMR_W-1:0] tmr, idle_cnt;
  logic        cap_rw, cap_uds, cap_lds;
  logic [22:0] cap_a;
  logic [15:0] cap_wd;
  state_t cyc, cyc_nxt;

  always_ff @(posedge CLK8) begin
    if (!RST) {bg_q, bgack_q, as_q, dtack_q, berr_q} <= '1;
    else      {bg_q, bgack_q, as_q, dtack_q, berr_q} <= {BG, BGACK_IN, AS_IN, DTACK, BERR};
  end

  bus_arbiter u_arb (
    .CLK8        (CLK8),
    .RST         (RST),
    .REQ         (REQ),
    .BG          (bg_q),
    .BGACK_IN    (bgack_q),
    .AS_IN       (as_q),
    .DTACK       (dtack_q),
    .RELEASE_REQ (release_req),
    .BR          (BR),
    .BGACK_OUT   (BGACK_OUT),
    .BUS_OE      (BUS_OE),
    .OWNED       (owned)
  );

  always_ff @(posedge CLK8) begin
    if (!RST) cyc <= IDLE;
    else      cyc <= cyc_nxt;
  end

  always_comb begin
    cyc_nxt     = cyc;
    req_go      = 1'b0;
    req_bad     = 1'b0;
    fin_ok      = 1'b0;
    fin_err     = 1'b0;
    idle_tick   = 1'b0;
    release_req = 1'b0;
    case (cyc)
      IDLE: if (owned) begin
        // REQ is still high during our own ACK clock; that is not a new request
        if (REQ && !ACK) begin
          if (REQ_UDS && REQ_LDS) req_bad = 1'b1;
          else begin
            req_go  = 1'b1;
            cyc_nxt = S_ADDR;
          end
        end else begin
          idle_tick = 1'b1;
          if (!REQ_LOCK || (idle_cnt >= HOLD_LAST)) release_req = 1'b1;
        end
      end
      S_ADDR: cyc_nxt = S_STRB;
      S_STRB: cyc_nxt = S_WAIT;
      S_WAIT: begin
        if (!berr_q) begin
          fin_err = 1'b1;
          cyc_nxt = S_END;
        end else if (!dtack_q) begin
          cyc_nxt = S_DATA;
        end else if (tmr == TMO_LAST) begin
          fin_err = 1'b1;
          cyc_nxt = S_END;
        end
      end
      S_DATA: begin
        fin_ok  = 1'b1;
        cyc_nxt = S_END;
      end
      S_END:   cyc_nxt = IDLE;
      default: cyc_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_cyc   = (cyc == S_ADDR) || (cyc == S_STRB) || (cyc == S_WAIT) ||
               (cyc == S_DATA) || (cyc == S_END);
    as_low   = (cyc == S_STRB) || (cyc == S_WAIT) || (cyc == S_DATA);
    // writes hold the data strobes off until the data has had a clock to settle
    strb_low = cap_rw ? as_low : ((cyc == S_WAIT) || (cyc == S_DATA));
    AS_OUT   = !as_low;
    UDS_OUT  = !(strb_low && !cap_uds);
    LDS_OUT  = !(strb_low && !cap_lds);
    RW_OUT   = in_cyc ? cap_rw : 1'b1;
    D_OE     = in_cyc && !cap_rw;
    A_OUT    = cap_a;
    D_OUT    = cap_wd;
  end

  always_ff @(posedge CLK8) begin
    if (!RST) begin
      ACK      <= 1'b0;
      ERR      <= 1'b0;
      RD       <= '0;
      tmr      <= '0;
      idle_cnt <= '0;
      cap_rw   <= 1'b1;
      cap_uds  <= 1'b1;
      cap_lds  <= 1'b1;
      cap_a    <= '0;
      cap_wd   <= '0;
    end else begin
      ACK      <= req_bad | fin_ok | fin_err;
      ERR      <= req_bad | fin_err;
      tmr      <= (cyc == S_WAIT) ? tmr + TMR_W'(1) : '0;
      idle_cnt <= idle_tick ? idle_cnt + TMR_W'(1) : '0;
      if (fin_ok && cap_rw) RD <= D_IN;
      if (req_go) begin
        cap_rw  <= REQ_RW;
        cap_uds <= REQ_UDS;
        cap_lds <= REQ_LDS;
        cap_a   <= REQ_A;
        cap_wd  <= REQ_WD;
      end
    end
  end

endmodule
